// File: rtl/ball_controller.sv
// ball_controller -- moves a Pong ball around a 640x480 field.
//
// The ball advances once per movement tick (one tick every 2^TICK_BITS
// clocks). It bounces off the top/bottom walls and off either paddle face.
// A ball that gets past a paddle scores a point for the opposite player,
// freezes for 64 ticks, then returns to the centre and waits for a serve.
//
// Optional feature (compile-time macro BALL_SPEEDUP_EN):
//   defined   -> every paddle bounce raises the speed by one pixel/tick,
//                saturating at 4; a serve resets the speed to 1.
//   undefined -> speed is fixed at 1 and no speed register exists.
//
// Ports:
//   clk       in   system clock
//   rst       in   asynchronous, active-high reset
//   serve_n   in   serve button, active-low level, honoured only in IDLE
//   p1_y      in   [9:0] left paddle centre Y (pixels)
//   p2_y      in   [9:0] right paddle centre Y (pixels)
//   bat_size  in   1: paddle half-height 40, 0: half-height 50
//   ball_x    out  [9:0] ball centre X
//   ball_y    out  [9:0] ball centre Y
//   in_play   out  high while the ball is live (state PLAY)
//   p1_point  out  1-clk pulse when the left player scores
//   p2_point  out  1-clk pulse when the right player scores
//
// There is no valid/ready handshake on this block: inputs are levels that
// are sampled on movement ticks (paddles) or on any clock in IDLE (serve),
// and every output is a register.

module ball_controller #(
  parameter int TICK_BITS = 17
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       serve_n,
  input  logic [9:0] p1_y,
  input  logic [9:0] p2_y,
  input  logic       bat_size,
  output logic [9:0] ball_x,
  output logic [9:0] ball_y,
  output logic       in_play,
  output logic       p1_point,
  output logic       p2_point
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PLAY   = 2'd1,
    SCORED = 2'd2
  } state_t;

  localparam logic [9:0]        X_CENTRE     = 10'd320;
  localparam logic [9:0]        Y_CENTRE     = 10'd240;
  localparam logic signed [10:0] Y_MIN        = 11'sd4;
  localparam logic signed [10:0] Y_MAX        = 11'sd475;
  localparam logic signed [10:0] LEFT_BOUNCE  = 11'sd34;
  localparam logic signed [10:0] RIGHT_BOUNCE = 11'sd606;
  localparam logic signed [10:0] LEFT_GOAL    = 11'sd4;
  localparam logic signed [10:0] RIGHT_GOAL   = 11'sd635;
  // Paddle half-height plus the ball radius: the widest |y - paddle_y|
  // that still counts as a hit.
  localparam logic signed [10:0] REACH_SMALL  = 11'sd44;
  localparam logic signed [10:0] REACH_LARGE  = 11'sd54;

  state_t               state;
  logic [TICK_BITS-1:0] div_cnt;
  logic                 tick;
  logic                 dx;           // 1: moving right (+x)
  logic                 dy;           // 1: moving down (+y)
  logic [5:0]           score_timer;

`ifdef BALL_SPEEDUP_EN
  logic [2:0] speed;
`else
  localparam logic [2:0] speed = 3'd1;
`endif

  assign tick = (div_cnt == '0);

  // Candidate move and paddle tests, all in 11-bit signed so that moves
  // past either edge of the field never wrap.
  logic signed [10:0] cur_x, cur_y, spd;
  logic signed [10:0] nx, ny;
  logic signed [10:0] d1, d2, a1, a2, reach;
  logic               hit_left, hit_right;

  always_comb begin
    cur_x = signed'({1'b0, ball_x});
    cur_y = signed'({1'b0, ball_y});
    spd   = signed'({8'd0, speed});
    nx    = dx ? (cur_x + spd) : (cur_x - spd);
    ny    = dy ? (cur_y + spd) : (cur_y - spd);
    // Paddle alignment uses the pre-move y.
    d1    = cur_y - signed'({1'b0, p1_y});
    d2    = cur_y - signed'({1'b0, p2_y});
    a1    = d1[10] ? -d1 : d1;
    a2    = d2[10] ? -d2 : d2;
    reach = bat_size ? REACH_SMALL : REACH_LARGE;
    hit_left  = !dx && (cur_x >= LEFT_BOUNCE)  && (nx <= LEFT_BOUNCE)  && (a1 <= reach);
    hit_right =  dx && (cur_x <= RIGHT_BOUNCE) && (nx >= RIGHT_BOUNCE) && (a2 <= reach);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      div_cnt     <= TICK_BITS'(1);
      ball_x      <= X_CENTRE;
      ball_y      <= Y_CENTRE;
      dx          <= 1'b1;
      dy          <= 1'b1;
      score_timer <= 6'd0;
      in_play     <= 1'b0;
      p1_point    <= 1'b0;
      p2_point    <= 1'b0;
`ifdef BALL_SPEEDUP_EN
      speed       <= 3'd1;
`endif
    end else begin
      div_cnt  <= div_cnt + 1'b1;
      p1_point <= 1'b0;
      p2_point <= 1'b0;

      case (state)
        IDLE: begin
          if (!serve_n) begin
            state   <= PLAY;
            in_play <= 1'b1;
`ifdef BALL_SPEEDUP_EN
            speed   <= 3'd1;
`endif
          end
        end

        PLAY: begin
          if (tick) begin
            // Vertical axis: walls only.
            if (ny <= Y_MIN) begin
              ball_y <= 10'd4;
              dy     <= 1'b1;
            end else if (ny >= Y_MAX) begin
              ball_y <= 10'd475;
              dy     <= 1'b0;
            end else begin
              ball_y <= ny[9:0];
            end

            // Horizontal axis: paddle bounce wins over a goal; a crossing
            // that misses the paddle just keeps moving.
            if (hit_left) begin
              ball_x <= 10'd34;
              dx     <= 1'b1;
`ifdef BALL_SPEEDUP_EN
              speed  <= (speed >= 3'd4) ? 3'd4 : speed + 3'd1;
`endif
            end else if (hit_right) begin
              ball_x <= 10'd606;
              dx     <= 1'b0;
`ifdef BALL_SPEEDUP_EN
              speed  <= (speed >= 3'd4) ? 3'd4 : speed + 3'd1;
`endif
            end else if (nx <= LEFT_GOAL) begin
              // Right player scores; next serve heads toward the loser's
              // opponent, i.e. to the right.
              ball_x      <= 10'd4;
              p2_point    <= 1'b1;
              dx          <= 1'b1;
              state       <= SCORED;
              in_play     <= 1'b0;
              score_timer <= 6'd0;
            end else if (nx >= RIGHT_GOAL) begin
              ball_x      <= 10'd635;
              p1_point    <= 1'b1;
              dx          <= 1'b0;
              state       <= SCORED;
              in_play     <= 1'b0;
              score_timer <= 6'd0;
            end else begin
              ball_x <= nx[9:0];
            end
          end
        end

        SCORED: begin
          // Frozen for 64 ticks: counts 0..63, leaves on the 64th tick.
          if (tick) begin
            if (score_timer == 6'd63) begin
              score_timer <= 6'd0;
              ball_x      <= X_CENTRE;
              ball_y      <= Y_CENTRE;
              state       <= IDLE;
            end else begin
              score_timer <= score_timer + 6'd1;
            end
          end
        end

        default: begin
          state   <= IDLE;
          in_play <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ball_controller.sv
// Testbench for ball_controller with TICK_BITS=4 (one tick every 16 clocks).
// The driver pushes every expected output change (with the cycle number at
// which it must appear) into exp_q; an independent monitor watches the DUT
// outputs on the falling edge and pops/compares on every change.

module tb_ball_controller;

  localparam int TICK_BITS = 4;
  localparam int W = 20 + 10 + 10 + 3;
`ifdef BALL_SPEEDUP_EN
  localparam int STEP_AFTER_BOUNCE = 2;
`else
  localparam int STEP_AFTER_BOUNCE = 1;
`endif

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       serve_n;
  logic [9:0] p1_y, p2_y;
  logic       bat_size;
  logic [9:0] ball_x, ball_y;
  logic       in_play, p1_point, p2_point;

  always #5 clk = ~clk;

  // Cycles since reset release; tick edges are the multiples of 16.
  logic [19:0] cyc = 20'd0;
  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 20'd0;
    else     cyc <= cyc + 20'd1;
  end

  ball_controller #(.TICK_BITS(TICK_BITS)) dut (
    .clk      (clk),
    .rst      (rst),
    .serve_n  (serve_n),
    .p1_y     (p1_y),
    .p2_y     (p2_y),
    .bat_size (bat_size),
    .ball_x   (ball_x),
    .ball_y   (ball_y),
    .in_play  (in_play),
    .p1_point (p1_point),
    .p2_point (p2_point)
  );

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int           n_vec  = 0;
  int           n_miss = 0;
  logic         drain   = 1'b0;
  logic         drained = 1'b0;

  task automatic push(input int c, input int x, input int y,
                      input bit ip, input bit p1, input bit p2);
    exp_q.push_back({c[19:0], x[9:0], y[9:0], ip, p1, p2});
  endtask

  // ---------------- monitor ----------------
  logic [22:0]  cur_obs;
  logic [22:0]  prev_obs = 'x;
  logic [W-1:0] exp_e;

  initial begin
    forever begin
      @(negedge clk);
      cur_obs = {ball_x, ball_y, in_play, p1_point, p2_point};
      if (cur_obs !== prev_obs) begin
        prev_obs = cur_obs;
        n_vec++;
        if (exp_q.size() == 0) begin
          n_miss++;
          $display("FAIL unexpected_change: got cyc=%0d x=%0d y=%0d ip=%0b p1=%0b p2=%0b, want no change",
                   cyc, ball_x, ball_y, in_play, p1_point, p2_point);
        end else begin
          exp_e = exp_q.pop_front();
          if ({cyc, cur_obs} !== exp_e) begin
            n_miss++;
            $display("FAIL vec%0d: got cyc=%0d x=%0d y=%0d ip=%0b p1=%0b p2=%0b, want cyc=%0d x=%0d y=%0d ip=%0b p1=%0b p2=%0b",
                     n_vec, cyc, ball_x, ball_y, in_play, p1_point, p2_point,
                     exp_e[42:23], exp_e[22:13], exp_e[12:3], exp_e[2], exp_e[1], exp_e[0]);
          end
        end
      end
      if (drain && !drained) begin
        drained = 1'b1;
        while (exp_q.size() > 0) begin
          exp_e = exp_q.pop_front();
          n_vec++;
          n_miss++;
          $display("FAIL missing_change: got nothing, want cyc=%0d x=%0d y=%0d ip=%0b p1=%0b p2=%0b",
                   exp_e[42:23], exp_e[22:13], exp_e[12:3], exp_e[2], exp_e[1], exp_e[0]);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_until(input int c);
    while (int'(cyc) < c) @(negedge clk);
  endtask

  // Called on a falling edge: serve_n is low for exactly one rising edge.
  task automatic serve();
    serve_n = 1'b0;
    @(negedge clk);
    serve_n = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int x, y;
    serve_n  = 1'b1;
    p1_y     = 10'd240;
    p2_y     = 10'd424;
    bat_size = 1'b0;
    push(0, 320, 240, 0, 0, 0);               // reset state
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // A: 100 idle ticks, serve, wall bounce at tick 235, right paddle
    // bounce at tick 286 (p2_y=424, half-height 50).
    push(1606, 320, 240, 1, 0, 0);
    for (int n = 1; n <= 290; n++) begin
      y = (n <= 235) ? 240 + n : 475 - (n - 235);
      x = (n <= 286) ? 320 + n : 606 - (n - 286) * STEP_AFTER_BOUNCE;
      push(16 * (100 + n), x, y, 1, 0, 0);
    end
    wait_until(1605);
    serve();

    // Asynchronous reset in mid-play: outputs snap back before the next
    // falling edge, with no point pulse.
    wait_until(16 * 390 + 5);
    push(0, 320, 240, 0, 0, 0);
    #3 rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // B: p2_y far away -> ball exits right, p1 scores at tick 315.
    p2_y = 10'd100;
    push(6, 320, 240, 1, 0, 0);
    for (int n = 1; n <= 314; n++) begin
      y = (n <= 235) ? 240 + n : 475 - (n - 235);
      push(16 * n, 320 + n, y, 1, 0, 0);
    end
    push(16 * 315,     635, 395, 0, 1, 0);
    push(16 * 315 + 1, 635, 395, 0, 0, 0);
    push(16 * 379,     320, 240, 0, 0, 0);
    wait_until(5);
    serve();

    // C: serve heads left (dx=-) with dy=- retained; top wall at tick 236;
    // left paddle 45/46 px off with reach 44 -> miss, p2 scores at tick 316.
    wait_until(6069);
    p1_y     = 10'd99;
    bat_size = 1'b1;
    push(6070, 320, 240, 1, 0, 0);
    for (int n = 1; n <= 315; n++) begin
      y = (n <= 236) ? 240 - n : 4 + (n - 236);
      push(16 * (379 + n), 320 - n, y, 1, 0, 0);
    end
    push(16 * 695,     4, 84, 0, 0, 1);
    push(16 * 695 + 1, 4, 84, 0, 0, 0);
    push(16 * 759,     320, 240, 0, 0, 0);
    serve();

    // D: after p2 scores the next serve heads right, dy=+ retained.
    wait_until(12149);
    push(12150, 320, 240, 1, 0, 0);
    push(12160, 321, 241, 1, 0, 0);
    push(12176, 322, 242, 1, 0, 0);
    serve();
    wait_until(12180);

    drain = 1'b1;
    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  // Watchdog: the whole run is under 20k clocks.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no end of test, want finish before 200000 clocks");
    $fatal(1);
  end

endmodule

// File: doc/ball_controller.md
BALL_CONTROLLER -- requirements
Module: ball_controller

Interface
REQ-001 SHALL have parameter TICK_BITS, default 17; width of the movement-tick divider, with one tick every 2^TICK_BITS clocks.
REQ-002 SHALL have port clk, input, 1 bit; system clock.
REQ-003 SHALL have port rst, input, 1 bit; reset, asynchronous, active-high.
REQ-004 SHALL have port serve_n, input, 1 bit; serve button, active-low level.
REQ-005 SHALL have port p1_y, input, 10 bits; left paddle centre Y, in pixels.
REQ-006 SHALL have port p2_y, input, 10 bits; right paddle centre Y, in pixels.
REQ-007 SHALL have port bat_size, input, 1 bit; 1 gives paddle half-height 40, 0 gives half-height 50.
REQ-008 SHALL have port ball_x, output, 10 bits; ball centre X.
REQ-009 SHALL have port ball_y, output, 10 bits; ball centre Y.
REQ-010 SHALL have port in_play, output, 1 bit; high only in state PLAY.
REQ-011 SHALL have port p1_point, output, 1 bit; 1-clk pulse when the left player scores.
REQ-012 SHALL have port p2_point, output, 1 bit; 1-clk pulse when the right player scores.

Function
REQ-013 Tick divider: TICK_BITS counter, reset value 1, +1 every clk, free-running with wrap; tick asserted when the counter equals 0.
REQ-014 Field: 640x480; ball radius 4; ball_y legal range 4..475.
REQ-015 Paddle faces: left paddle face at X=30, with bounce X=34; right paddle face at X=610, with bounce X=606.
REQ-016 Direction state: registers dx and dy (1 = +, 0 = -) and a 3-bit speed (pixels per tick).
REQ-017 States: IDLE, PLAY and SCORED.
REQ-018 IDLE: ball held at (320,240); serve_n low on any clk moves to PLAY on the next clk and loads speed=1.
REQ-019 PLAY: on each tick, nx = x ± speed and ny = y ± speed, computed in 11-bit signed arithmetic with no wrap-around.
REQ-020 Vertical wall: ny <= 4 gives y=4, dy=+; ny >= 475 gives y=475, dy=-.
REQ-021 Left paddle crossing: dx=-, x >= 34, nx <= 34, and |y - p1_y| <= half+4 gives x=34, dx=+ (bounce).
REQ-022 Right paddle crossing: dx=+, x <= 606, nx >= 606, and |y - p2_y| <= half+4 gives x=606, dx=- (bounce).
REQ-023 The paddle test SHALL use the pre-move y; a missed crossing continues movement unmodified.
REQ-024 Miss: nx <= 4 gives x=4, p2_point pulse, go to SCORED; nx >= 635 gives x=635, p1_point pulse, go to SCORED.
REQ-025 Wall and paddle/miss resolution on the same tick SHALL both apply, each to its own axis.
REQ-026 SCORED: ball frozen for 64 ticks, then ball goes to (320,240) and state to IDLE.
REQ-027 After p1_point the next serve dx=-; after p2_point the next serve dx=+; dy is retained.
REQ-028 serve_n SHALL be ignored outside IDLE.
REQ-029 p1_y, p2_y and bat_size SHALL be sampled only on ticks in PLAY.
REQ-030 Outputs SHALL be registered, with no combinational path from input to output.

Reset
REQ-031 On rst: ball_x=320, ball_y=240, dx=+, dy=+, speed=1, state IDLE, in_play=0, p1_point=0, p2_point=0, divider=1, SCORED timer=0.
REQ-032 rst asserted mid-PLAY or mid-SCORED SHALL abort immediately with no point pulse; play resumes only via a new serve.

Configuration
REQ-033 Macro BALL_SPEEDUP_EN defined: each paddle bounce sets speed = min(speed+1, 4); speed returns to 1 on serve.
REQ-034 Macro BALL_SPEEDUP_EN undefined: speed constant at 1, with no speed logic synthesized.

Verification
REQ-035 With TICK_BITS=4: rst, serve_n high for 100 ticks -> ball stays (320,240), in_play=0, no point pulses.
REQ-036 serve_n low for 1 clk -> in_play=1 on the next clk; first tick gives ball (321,241).
REQ-037 After serve, tick 235 -> ball_y=475; tick 236 -> ball_y=474 (dy flipped); ball_x unaffected.
REQ-038 bat_size=0, p2_y=424 -> at tick 286 ball_x=606; tick 287 gives ball_x=605; with BALL_SPEEDUP_EN, tick 287 gives ball_x=604.
REQ-039 p2_y=100 -> no bounce; p1_point is a single 1-clk pulse when ball_x=635; 64 ticks later ball is (320,240), in_play=0; next serve moves ball_x toward 319.
REQ-040 rst pulsed mid-PLAY -> outputs equal reset values within the same cycle (asynchronous), with no point pulse.
